median_window_tx: RTL and testbench
===================================

Name: median_window_tx

Overview:
- Initiator side of the median filter stream: walks a stored IMG_W x IMG_H image and feeds 3x3 neighbourhoods, nine pixels per burst, to the median unit on DI/DSI.
- Waits for the median unit's DSO strobe, captures its DO result and writes the filtered pixel to an output memory.
- Border pixels are copied through unfiltered.
- Sits between the image RAMs and the median unit, started by a host pulse.

Parameters:
- WIDTH, 8, pixel width in bits.
- IMG_W, 16, image width in pixels (>=3).
- IMG_H, 16, image height in pixels (>=3).
- AW, 8, memory address width; IMG_W*IMG_H <= 2**AW.
- TIMEOUT, 64, max cycles waiting for MDSO before abort.

Ports:
- CLK  in  1  clock, all logic on rising edge
- nRST  in  1  asynchronous active-low reset
- START  in  1  one-cycle start pulse
- BUSY  out  1  high while a frame is processed
- DONE  out  1  one-cycle pulse at end of frame
- ERR  out  1  sticky, set on median timeout; cleared by next accepted START
- RADDR  out  AW  source image read address
- RDATA  in  WIDTH  source data, valid one cycle after RADDR
- MDI  out  WIDTH  pixel to median unit DI
- MDSI  out  1  pixel strobe to median unit DSI
- MDO  in  WIDTH  median unit DO
- MDSO  in  1  median unit DSO
- WADDR  out  AW  result write address
- WDATA  out  WIDTH  result data
- WE  out  1  result write enable

Behaviour:
- Reset (async, nRST low): state IDLE. BUSY, DONE, ERR, MDSI and WE are 0. RADDR, WADDR, WDATA, row and col are 0. MDI = RDATA passthrough, don't-care while MDSI is 0.
- Address: addr = row*IMG_W + col. Pixels are processed in raster order (row 0..IMG_H-1, col 0..IMG_W-1).
- IDLE: START -> clear ERR, row=col=0, BUSY=1, go SEL. START while BUSY is ignored.
- SEL: decide the pixel type.
  - Border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1) -> BRD_RD.
  - Otherwise -> FETCH, with window index k=0.
- BRD_RD: RADDR=addr for 1 cycle. Next cycle BRD_WR: WE=1, WADDR=addr, WDATA=RDATA. Then go NEXT.
- FETCH: 9 consecutive cycles, k=0..8.
  - RADDR=(row-1+k/3)*IMG_W + (col-1+k%3).
  - MDSI is a 1-cycle delayed copy of the fetch-active flag, so MDSI is high for exactly 9 consecutive cycles, the first one cycle after k=0 is issued. MDI=RDATA during those cycles.
  - No gaps are permitted inside a burst.
  - After k=8 go WAIT and clear the timeout counter.
- WAIT: count cycles.
  - MDSO=1 -> capture MDO into WDATA, go WR.
  - Counter reaches TIMEOUT -> set ERR and go FIN; the frame is abandoned.
  - An MDSO arriving during the last MDSI cycle is not possible by construction. An MDSO seen in any other state is ignored.
- WR: WE=1 for 1 cycle, WADDR=addr, WDATA=captured median. Then go NEXT.
- NEXT: advance the position.
  - col wraps at IMG_W-1 to 0 with row+1.
  - After row IMG_H-1, col IMG_W-1 -> FIN. Otherwise -> SEL.
- FIN: DONE=1 for 1 cycle, BUSY=0, go IDLE.
- WE is never high in the same cycle as MDSI.
- Exactly IMG_W*IMG_H writes per frame, each address written once.
- Reset mid-frame: immediate abort to reset values; no partial DONE. The median unit is reset by the same system reset.
- Arithmetic: address maths is unsigned, truncated to AW bits. Window offsets stay in range because only interior pixels are filtered.

Decomposition:
- Package median_pkg:
  - state enum (IDLE, SEL, BRD_RD, BRD_WR, FETCH, WAIT, WR, NEXT, FIN)
  - window length constant 9
  - row/col offset tables for k=0..8
- Sub-module median_win_addr: combinational (row, col, k) -> RADDR, plus the is_border flag.

Test Plan:
- 3x3 image, source = 1..9 row-major, median model echoes the 5th pixel with DSO 30 cycles after the last DSI.
  - MDSI is high for 9 consecutive cycles with MDI=1..9.
  - Centre write (WADDR=4) = 5.
  - The 8 border writes equal the source.
  - DONE fires once.
- 16x16 image of random pixels with a reference median model.
  - Output memory equals software median for interior pixels and equals the source on borders.
  - 256 WE pulses in total.
- START pulsed again while BUSY: no restart; DONE count = 1.
- Median model never asserts DSO.
  - ERR=1 after exactly TIMEOUT cycles in WAIT, then DONE, then BUSY=0.
  - The next START clears ERR.
- nRST low during the third FETCH burst.
  - All outputs go to reset values asynchronously, before the next CLK edge.
  - A subsequent START processes the full frame correctly.
- Spurious MDSO pulses injected during FETCH and during border copy produce no extra writes.

Source files
------------

// File: rtl/median_pkg.sv
// Shared definitions for the median window initiator.
// - state_t          : controller states
// - WIN_LEN          : pixels per 3x3 burst
// - ROW_OFS, COL_OFS : window offsets for k=0..8, biased by +1 so they stay
//                      unsigned (the actual offset is value-1)
package median_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SEL,
    BRD_RD,
    BRD_WR,
    FETCH,
    WAIT,
    WR,
    NEXT,
    FIN
  } state_t;

  localparam int unsigned WIN_LEN = 9;

  localparam logic [1:0] ROW_OFS [WIN_LEN] = '{2'd0, 2'd0, 2'd0,
                                               2'd1, 2'd1, 2'd1,
                                               2'd2, 2'd2, 2'd2};
  localparam logic [1:0] COL_OFS [WIN_LEN] = '{2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/median_win_addr.sv
// Combinational address generator.
// Inputs : row, col (current pixel), k (window index 0..8)
// Outputs: pix_addr  = row*IMG_W + col
//          win_addr  = (row-1+k/3)*IMG_W + (col-1+k%3)
//          is_border = pixel lies on the outer frame of the image
// All arithmetic is unsigned and truncated to AW bits.
module median_win_addr
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned AW    = 8
) (
  input  logic [AW-1:0] row,
  input  logic [AW-1:0] col,
  input  logic [3:0]    k,
  output logic [AW-1:0] pix_addr,
  output logic [AW-1:0] win_addr,
  output logic          is_border
);

  logic [AW-1:0] win_row;
  logic [AW-1:0] win_col;

  always_comb begin
    // Offset tables are biased by +1, so subtract it back here.
    win_row   = row + AW'(ROW_OFS[k]) - AW'(1);
    win_col   = col + AW'(COL_OFS[k]) - AW'(1);
    pix_addr  = row * AW'(IMG_W) + col;
    win_addr  = win_row * AW'(IMG_W) + win_col;
    is_border = (row == '0) || (row == AW'(IMG_H - 1)) ||
                (col == '0) || (col == AW'(IMG_W - 1));
  end

endmodule

// File: rtl/median_window_tx.sv
// Median filter stream initiator.
// Walks an IMG_W x IMG_H source image in raster order. Interior pixels are
// sent as 9-pixel 3x3 bursts on MDI/MDSI; the result returned on MDO/MDSO is
// written to the output memory. Border pixels are copied through unchanged.
// Ports:
//   CLK, nRST         clock, asynchronous active-low reset
//   START/BUSY/DONE   host handshake; ERR sticky median-timeout flag
//   RADDR/RDATA       source RAM (RDATA valid one cycle after RADDR)
//   MDI/MDSI          pixel stream to median unit
//   MDO/MDSO          median result from median unit
//   WADDR/WDATA/WE    result RAM write port
module median_window_tx
  import median_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned IMG_W   = 16,
  parameter int unsigned IMG_H   = 16,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [AW-1:0]    RADDR,
  input  logic [WIDTH-1:0] RDATA,
  output logic [WIDTH-1:0] MDI,
  output logic             MDSI,
  input  logic [WIDTH-1:0] MDO,
  input  logic             MDSO,
  output logic [AW-1:0]    WADDR,
  output logic [WIDTH-1:0] WDATA,
  output logic             WE
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  state_t        state;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [3:0]    k;
  logic [3:0]    k_nxt;
  logic [TW-1:0] tcnt;
  logic [AW-1:0] pix_addr;
  logic [AW-1:0] win_addr;
  logic          is_border;

  // k holds the index currently on RADDR; the generator is fed the index
  // that will be issued next (0 when entering the burst from SEL).
  always_comb begin
    k_nxt = (state == FETCH) ? k + 4'd1 : '0;
  end

  median_win_addr #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .AW   (AW)
  ) u_addr (
    .row      (row),
    .col      (col),
    .k        (k_nxt),
    .pix_addr (pix_addr),
    .win_addr (win_addr),
    .is_border(is_border)
  );

  // Source data is forwarded directly; it is only meaningful while MDSI=1.
  assign MDI = RDATA;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      k     <= '0;
      tcnt  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      MDSI  <= 1'b0;
      WE    <= 1'b0;
      RADDR <= '0;
      WADDR <= '0;
      WDATA <= '0;
    end else begin
      DONE <= 1'b0;
      WE   <= 1'b0;
      // RDATA lags RADDR by one cycle, so the strobe lags the fetch state.
      MDSI <= (state == FETCH);
      case (state)
        IDLE: begin
          if (START) begin
            ERR   <= 1'b0;
            row   <= '0;
            col   <= '0;
            BUSY  <= 1'b1;
            state <= SEL;
          end
        end
        SEL: begin
          if (is_border) begin
            RADDR <= pix_addr;
            state <= BRD_RD;
          end else begin
            RADDR <= win_addr;
            k     <= '0;
            state <= FETCH;
          end
        end
        BRD_RD: state <= BRD_WR;
        BRD_WR: begin
          WE    <= 1'b1;
          WADDR <= pix_addr;
          WDATA <= RDATA;
          state <= NEXT;
        end
        FETCH: begin
          if (k == 4'(WIN_LEN - 1)) begin
            tcnt  <= '0;
            state <= WAIT;
          end else begin
            k     <= k_nxt;
            RADDR <= win_addr;
          end
        end
        WAIT: begin
          if (MDSO) begin
            WDATA <= MDO;
            state <= WR;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            ERR   <= 1'b1;
            state <= FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WR: begin
          WE    <= 1'b1;
          WADDR <= pix_addr;
          state <= NEXT;
        end
        NEXT: begin
          if (col == AW'(IMG_W - 1)) begin
            col <= '0;
            if (row == AW'(IMG_H - 1)) begin
              state <= FIN;
            end else begin
              row   <= row + AW'(1);
              state <= SEL;
            end
          end else begin
            col   <= col + AW'(1);
            state <= SEL;
          end
        end
        FIN: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_tx.sv
// Bench for median_window_tx: a 16x16 instance (index 0) and a 3x3 instance
// (index 1) share clock and reset. Each has a source RAM, a median-unit model
// and a write logger; results are compared with a software 3x3 median.
module tb_median_window_tx;

  localparam int unsigned TO = 64;
  localparam int unsigned BW = 16;
  localparam int unsigned BH = 16;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic       start [2];
  logic [7:0] rdata [2];
  logic [7:0] mdo   [2];
  logic       mdso  [2];

  logic       b_busy, b_done, b_err, b_mdsi, b_we;
  logic [7:0] b_raddr, b_mdi, b_waddr, b_wdata;
  logic       s_busy, s_done, s_err, s_mdsi, s_we;
  logic [7:0] s_raddr, s_mdi, s_waddr, s_wdata;

  logic       busy [2], done [2], err [2], mdsi [2], we [2];
  logic [7:0] raddr [2], mdi [2], waddr [2], wdata [2];

  median_window_tx #(.WIDTH(8), .IMG_W(BW), .IMG_H(BH), .AW(8), .TIMEOUT(TO)) u_big (
    .CLK(clk), .nRST(nrst), .START(start[0]), .BUSY(b_busy), .DONE(b_done), .ERR(b_err),
    .RADDR(b_raddr), .RDATA(rdata[0]), .MDI(b_mdi), .MDSI(b_mdsi), .MDO(mdo[0]),
    .MDSO(mdso[0]), .WADDR(b_waddr), .WDATA(b_wdata), .WE(b_we));

  median_window_tx #(.WIDTH(8), .IMG_W(3), .IMG_H(3), .AW(8), .TIMEOUT(TO)) u_small (
    .CLK(clk), .nRST(nrst), .START(start[1]), .BUSY(s_busy), .DONE(s_done), .ERR(s_err),
    .RADDR(s_raddr), .RDATA(rdata[1]), .MDI(s_mdi), .MDSI(s_mdsi), .MDO(mdo[1]),
    .MDSO(mdso[1]), .WADDR(s_waddr), .WDATA(s_wdata), .WE(s_we));

  always_comb begin
    busy[0] = b_busy;   busy[1] = s_busy;
    done[0] = b_done;   done[1] = s_done;
    err[0]  = b_err;    err[1]  = s_err;
    mdsi[0] = b_mdsi;   mdsi[1] = s_mdsi;
    we[0]   = b_we;     we[1]   = s_we;
    raddr[0] = b_raddr; raddr[1] = s_raddr;
    mdi[0]   = b_mdi;   mdi[1]   = s_mdi;
    waddr[0] = b_waddr; waddr[1] = s_waddr;
    wdata[0] = b_wdata; wdata[1] = s_wdata;
  end

  // Environment configuration (written by the stimulus process only).
  logic [7:0]  src  [2][256];
  int unsigned mode [2];   // 0: true median, 1: echo 5th pixel, 2: never answer
  logic        spur [2];   // inject spurious MDSO pulses
  int unsigned dcfg [2];   // response delay; 0 = random 1..20

  // Environment state (written by the model process only).
  logic [7:0]  outm  [2][256];
  int unsigned wmark [2][256];
  logic [7:0]  samp  [2][9];
  logic [7:0]  seq1  [9];
  int unsigned run [2], nb [2], badb [2], wcnt [2], dcnt [2], coll [2], dly [2];
  int unsigned t_last [2], t_err [2];
  logic        pend [2], errseen [2];
  int unsigned cyc = 0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] s [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) s[i] = v[i];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[4];
  endfunction

  // Expected filtered pixel of the 16x16 image.
  function automatic logic [7:0] ref_pix(input int r, input int c);
    logic [7:0] v [9];
    if (r == 0 || r == BH - 1 || c == 0 || c == BW - 1) return src[0][r*BW + c];
    for (int i = 0; i < 9; i++) v[i] = src[0][(r - 1 + i/3)*BW + (c - 1 + i%3)];
    return med9(v);
  endfunction

  always @(posedge clk) begin
    logic [7:0] tmp [9];
    for (int u = 0; u < 2; u++) begin
      rdata[u] <= src[u][raddr[u]];
      if (!nrst) begin
        mdso[u] <= 1'b0;
        mdo[u]  <= '0;
        run[u] = 0; nb[u] = 0; badb[u] = 0; wcnt[u] = 0; dcnt[u] = 0; coll[u] = 0;
        pend[u] = 1'b0; errseen[u] = 1'b0; t_last[u] = 0; t_err[u] = 0; dly[u] = 0;
        for (int a = 0; a < 256; a++) begin outm[u][a] = '0; wmark[u][a] = 0; end
      end else begin
        mdso[u] <= 1'b0;
        if (we[u]) begin
          wcnt[u]++;
          outm[u][waddr[u]] = wdata[u];
          wmark[u][waddr[u]]++;
          if (mdsi[u]) coll[u]++;
        end
        if (done[u]) dcnt[u]++;
        if (err[u] && !errseen[u]) begin errseen[u] = 1'b1; t_err[u] = cyc; end
        if (mdsi[u]) begin
          if (run[u] < 9) samp[u][run[u]] = mdi[u];
          if (u == 1 && nb[1] == 0 && run[1] < 9) seq1[run[1]] = mdi[1];
          run[u]++;
          if (run[u] == 9) begin
            pend[u] = 1'b1;
            t_last[u] = cyc;
            dly[u] = (dcfg[u] != 0) ? dcfg[u] : $urandom_range(1, 20);
          end
        end else if (run[u] != 0) begin
          if (run[u] != 9) badb[u]++;
          nb[u]++;
          run[u] = 0;
        end
        if (pend[u]) begin
          if (mode[u] != 2) begin
            if (dly[u] <= 1) begin
              for (int i = 0; i < 9; i++) tmp[i] = samp[u][i];
              mdso[u] <= 1'b1;
              mdo[u]  <= (mode[u] == 1) ? samp[u][4] : med9(tmp);
              pend[u] = 1'b0;
            end else begin
              dly[u]--;
            end
          end
        end else if (spur[u] && (!mdsi[u] || run[u] <= 7) && $urandom_range(0, 3) == 0) begin
          // Only lands in cycles where the initiator is not waiting for a result.
          mdso[u] <= 1'b1;
          mdo[u]  <= 8'hEE;
        end
      end
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic pulse_start(input int u);
    @(negedge clk);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget, input string tag);
    int n = 0;
    while (!done[u] && n < budget) begin @(negedge clk); n++; end
    check(tag, {31'd0, done[u]}, 32'd1);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    int unsigned bad = 0;
    int unsigned dup = 0;
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) begin
        if (outm[0][r*BW + c] !== ref_pix(r, c)) bad++;
        if (wmark[0][r*BW + c] != 1) dup++;
      end
    check({tag, "_pix_bad"},  bad, 0);
    check({tag, "_addr_dup"}, dup, 0);
    check({tag, "_writes"},   wcnt[0], BW*BH);
    check({tag, "_done_cnt"}, dcnt[0], 1);
    check({tag, "_bursts"},   nb[0], (BW-2)*(BH-2));
    check({tag, "_badburst"}, badb[0], 0);
    check({tag, "_we_mdsi"},  coll[0], 0);
    check({tag, "_err"},      {31'd0, err[0]}, 0);
    check({tag, "_busy"},     {31'd0, busy[0]}, 0);
  endtask

  initial begin
    int n;
    nrst = 1'b0;
    start = '{1'b0, 1'b0};
    mode = '{0, 0};
    spur = '{1'b0, 1'b0};
    dcfg = '{0, 0};
    for (int i = 0; i < 256; i++) begin
      src[0][i] = 8'($urandom);
      src[1][i] = (i < 9) ? 8'(i + 1) : 8'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_ctrl",  {27'd0, busy[0], done[0], err[0], mdsi[0], we[0]}, 0);
    check("rst_raddr", raddr[0], 0);
    check("rst_waddr", waddr[0], 0);
    check("rst_wdata", wdata[0], 0);
    nrst = 1'b1;

    // 3x3 frame: one burst 1..9, centre = 5, borders copied.
    mode[1] = 1; dcfg[1] = 30;
    pulse_start(1);
    wait_done(1, 2000, "small_done");
    check("small_bursts",   nb[1], 1);
    check("small_badburst", badb[1], 0);
    for (int i = 0; i < 9; i++) check("small_mdi", seq1[i], i + 1);
    check("small_writes", wcnt[1], 9);
    for (int a = 0; a < 9; a++) check("small_wr", outm[1][a], (a == 4) ? 5 : a + 1);
    check("small_done_cnt", dcnt[1], 1);
    check("small_we_mdsi",  coll[1], 0);
    check("small_busy",     {31'd0, busy[1]}, 0);

    // 16x16 random frame, spurious MDSO, START while busy.
    do_reset();
    mode[0] = 0; dcfg[0] = 0; spur[0] = 1'b1;
    pulse_start(0);
    repeat (40) @(negedge clk);
    check("busy_mid", {31'd0, busy[0]}, 1);
    pulse_start(0);
    wait_done(0, 30000, "big_done");
    check_frame("big");

    // Median unit silent: timeout abort.
    do_reset();
    spur[0] = 1'b0; mode[0] = 2;
    pulse_start(0);
    wait_done(0, 5000, "to_done");
    check("to_err",      {31'd0, err[0]}, 1);
    check("to_busy",     {31'd0, busy[0]}, 0);
    check("to_latency",  t_err[0] - t_last[0], TO);
    check("to_writes",   wcnt[0], BW + 1);
    check("to_done_cnt", dcnt[0], 1);
    mode[0] = 0;
    pulse_start(0);
    check("err_clear", {31'd0, err[0]}, 0);

    // Reset during the third burst, then a clean frame.
    do_reset();
    mode[0] = 0;
    pulse_start(0);
    n = 0;
    while (!(nb[0] == 2 && mdsi[0]) && n < 3000) begin @(negedge clk); n++; end
    check("third_burst", {31'd0, (nb[0] == 2 && mdsi[0])}, 1);
    check("no_early_done", dcnt[0], 0);
    nrst = 1'b0;
    #1;
    check("async_ctrl",  {27'd0, busy[0], done[0], err[0], mdsi[0], we[0]}, 0);
    check("async_raddr", raddr[0], 0);
    check("async_waddr", waddr[0], 0);
    check("async_wdata", wdata[0], 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    pulse_start(0);
    wait_done(0, 30000, "rerun_done");
    check_frame("rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
